// File: rtl/button_event_ctrl_pkg.sv
// Shared types and constants for the button event controller and its per-button FSMs.
package button_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } btn_state_t;

  localparam int unsigned MS_PER_SEC    = 1000;
  localparam int unsigned NUM_EVT_TYPES = 4;

  // Counter width able to hold the largest reload value, never narrower than 16 bits.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return ($clog2(m + 1) > 16) ? $clog2(m + 1) : 16;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event stream between the button controller and its consumer (valid/ready).
interface button_event_ctrl_if
  import button_pkg::*;
#(
  parameter int unsigned BTN_W = 2
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [BTN_W-1:0] evt_button;
  evt_type_t        evt_type;

  modport master (output evt_valid, output evt_button, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_button, input evt_type, output evt_ready);
endinterface

// File: rtl/button_event_ctrl_fsm.sv
// One button: two-flop synchronizer, debounce/hold FSM and its tick counter.
// LONG/REPEAT generation is built only when BUTTON_REPEAT_EN is defined.
module button_fsm
  import button_pkg::*;
#(
  parameter int unsigned ACTIVE      = 1,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pin_i,
  input  logic                     tick_i,
  output logic                     pressed_o,
  output logic [NUM_EVT_TYPES-1:0] post_o
);

  localparam int unsigned CNT_W   = cnt_width(DEBOUNCE_MS, LONG_MS, REPEAT_MS);
  localparam logic        ACT_LVL = (ACTIVE != 0);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t DB_LOAD = cnt_t'(DEBOUNCE_MS);
`ifdef BUTTON_REPEAT_EN
  localparam cnt_t LONG_LOAD = cnt_t'(LONG_MS);
  localparam cnt_t REP_LOAD  = cnt_t'(REPEAT_MS);
`endif

  logic       sync1_q, sync2_q, act, expire;
  btn_state_t state_q, state_d;
  cnt_t       cnt_q, cnt_d;
`ifdef BUTTON_REPEAT_EN
  logic       long_q, long_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= ~ACT_LVL;
      sync2_q <= ~ACT_LVL;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign act    = (sync2_q == ACT_LVL);
  // cnt_q==1 on a tick is the tick that would take the count to zero.
  assign expire = tick_i && (cnt_q <= cnt_t'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef BUTTON_REPEAT_EN
      long_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef BUTTON_REPEAT_EN
      long_q  <= long_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    post_o  = '0;
`ifdef BUTTON_REPEAT_EN
    long_d  = long_q;
`endif
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d = DB_PRESS;
          cnt_d   = DB_LOAD;
        end
      end
      DB_PRESS: begin
        if (!act) begin
          state_d = IDLE;
        end else if (expire) begin
          state_d           = HELD;
          post_o[EVT_PRESS] = 1'b1;
`ifdef BUTTON_REPEAT_EN
          cnt_d             = LONG_LOAD;
          long_d            = 1'b0;
`else
          cnt_d             = '0;
`endif
        end else if (tick_i) begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      HELD: begin
        if (!act) begin
          state_d = DB_REL;
          cnt_d   = DB_LOAD;
        end
`ifdef BUTTON_REPEAT_EN
        else if (expire) begin
          post_o[long_q ? EVT_REPEAT : EVT_LONG] = 1'b1;
          long_d = 1'b1;
          cnt_d  = REP_LOAD;
        end else if (tick_i) begin
          cnt_d = cnt_q - cnt_t'(1);
        end
`endif
      end
      DB_REL: begin
        if (act) begin
          state_d = HELD;
`ifdef BUTTON_REPEAT_EN
          cnt_d   = long_q ? REP_LOAD : LONG_LOAD;
`else
          cnt_d   = '0;
`endif
        end else if (expire) begin
          state_d             = IDLE;
          post_o[EVT_RELEASE] = 1'b1;
        end else if (tick_i) begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pressed_o = (state_q == HELD) || (state_q == DB_REL);

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-button controller: shared ms prescaler, per-button FSMs, pending bits and a
// round-robin arbiter onto one valid/ready event stream. BUTTON_REPEAT_EN enables LONG/REPEAT.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned ACTIVE      = 1,
  parameter int unsigned CLK_FREQ    = 100000000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] pin,
  output logic [NUM_BUTTONS-1:0] pressed,
  button_event_ctrl_if.master    evt,
  output logic                   overflow
);

  localparam int unsigned BTN_W    = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int unsigned TICK_DIV = CLK_FREQ / MS_PER_SEC;
  localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef BUTTON_REPEAT_EN
  localparam logic [NUM_EVT_TYPES-1:0] TYPE_MASK = 4'b1111;
`else
  localparam logic [NUM_EVT_TYPES-1:0] TYPE_MASK = 4'b1001;
`endif

  typedef logic [NUM_BUTTONS-1:0][NUM_EVT_TYPES-1:0] pend_t;

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick;
  pend_t            post, pend_q, pend_d, gmask;
  logic             load, found, grant;
  logic [BTN_W-1:0] gbtn, gnext, rr_q, rr_d, btn_q, btn_d;
  evt_type_t        gtype, type_q, type_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;

  assign tick    = (presc_q == PRE_W'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PRE_W'(1);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_fsm #(
      .ACTIVE      (ACTIVE),
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_fsm (
      .clk_i     (clk),
      .rst_i     (reset),
      .pin_i     (pin[g]),
      .tick_i    (tick),
      .pressed_o (pressed[g]),
      .post_o    (post[g])
    );
  end

  assign load  = !valid_q || evt.evt_ready;
  assign grant = load && found;

  // First button at or after rr_q with anything pending; lowest type wins within it.
  always_comb begin : arb_pick
    int unsigned cand, nxt;
    found = 1'b0;
    gbtn  = '0;
    gnext = '0;
    gtype = EVT_PRESS;
    cand  = 0;
    nxt   = 0;
    for (int unsigned k = 0; k < NUM_BUTTONS; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_BUTTONS) cand = cand - NUM_BUTTONS;
      if (!found && (|pend_q[BTN_W'(cand)])) begin
        found = 1'b1;
        gbtn  = BTN_W'(cand);
        nxt   = cand + 1;
        if (nxt >= NUM_BUTTONS) nxt = 0;
        gnext = BTN_W'(nxt);
        for (int unsigned t = 0; t < NUM_EVT_TYPES; t++) begin
          if (pend_q[BTN_W'(cand)][NUM_EVT_TYPES-1-t]) gtype = evt_type_t'(2'(NUM_EVT_TYPES-1-t));
        end
      end
    end
  end

  // Grant clears first and the new post is OR-ed after, so a simultaneous re-post survives.
  always_comb begin
    gmask = '0;
    if (grant) gmask[gbtn][gtype] = 1'b1;
    pend_d = ((pend_q & ~gmask) | post) & {NUM_BUTTONS{TYPE_MASK}};
    ovf_d  = ovf_q | (|(post & pend_q & ~gmask));
  end

  always_comb begin
    valid_d = valid_q;
    btn_d   = btn_q;
    type_d  = type_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        btn_d  = gbtn;
        type_d = gtype;
        rr_d   = gnext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      btn_q   <= '0;
      type_q  <= EVT_PRESS;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      btn_q   <= btn_d;
      type_q  <= type_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt.evt_valid  = valid_q;
  assign evt.evt_button = btn_q;
  assign evt.evt_type   = type_q;
  assign overflow       = ovf_q;

endmodule
